mem_arbiter_ctrl: RTL and testbench

Parametrised successor to the single-port memory controller. Arbitrates between the instruction-fetch port and the data port (read and write) onto one shared memory bus. Requests are registered, the command is held until the bus accepts it, read data is captured, and the requester gets a one-cycle ack. Sits between the CPU core (fetch and load/store units) and the bus/SRAM wrapper.

---
 rtl/mem_arbiter_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl.sv
// Two-port (instruction fetch / data load-store) arbiter onto one shared memory bus,
// with starvation guard for fetch. Optional bus-wait abort enabled by MEMCTRL_TIMEOUT_EN.
module mem_arbiter_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req,
    input  logic [ADDR_W-1:0]     instr_addr,
    output logic                  instr_ack,
    output logic [DATA_W-1:0]     instr_rdata,
    input  logic                  data_read,
    input  logic                  data_write,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    input  logic [DATA_W/8-1:0]   data_be,
    output logic                  data_ack,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  err,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic                  bus_read,
    output logic                  bus_write,
    input  logic                  bus_busy,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic [2:0]            state
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3
    } state_t;

    state_t             state_q;
    state_t             state_next;
    logic [CNT_W-1:0]   starve_cnt;
    logic               lat_instr;
    logic               lat_write;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [BE_W-1:0]    lat_be;
    logic               grant_instr;
    logic               grant_read;
    logic               grant_write;
    logic               grant_any;
    logic               accept;
    logic               abort;
    logic               cmd_active;

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]   tmo_cnt;
    logic               err_q;
`endif

    // Fetch wins only once data has been granted STARVE_LIMIT times in a row over it.
    always_comb begin
        grant_instr = 1'b0;
        grant_read  = 1'b0;
        grant_write = 1'b0;
        if (instr_req && starve_cnt == STARVE_MAX)
            grant_instr = 1'b1;
        else if (data_read)
            grant_read = 1'b1;
        else if (data_write)
            grant_write = 1'b1;
        else if (instr_req)
            grant_instr = 1'b1;
    end

    assign grant_any = grant_instr | grant_read | grant_write;

    always_comb begin
        state_next = state_q;
        accept     = 1'b0;
        abort      = 1'b0;
        case (state_q)
            IDLE: if (grant_any) state_next = REQ;
            REQ: begin
                if (!bus_busy) begin
                    state_next = DONE;
                    accept     = 1'b1;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!bus_busy) begin
                    state_next = DONE;
                    accept     = 1'b1;
                end
`ifdef MEMCTRL_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_next = DONE;
                    abort      = 1'b1;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_cnt  <= '0;
            lat_instr   <= 1'b0;
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_be      <= '0;
            instr_rdata <= '0;
            data_rdata  <= '0;
        end else begin
            state_q <= state_next;
            if (state_q == IDLE && grant_any) begin
                lat_instr <= grant_instr;
                lat_write <= grant_write;
                lat_addr  <= grant_instr ? instr_addr : data_addr;
                lat_wdata <= grant_instr ? '0 : data_wdata;
                lat_be    <= grant_write ? data_be : '1;
                if (grant_instr || !instr_req)
                    starve_cnt <= '0;
                else if (starve_cnt != STARVE_MAX)
                    starve_cnt <= starve_cnt + CNT_W'(1);
            end
            if (accept && !lat_write) begin
                if (lat_instr) instr_rdata <= bus_rdata;
                else           data_rdata  <= bus_rdata;
            end
            if (abort && !lat_write) begin
                if (lat_instr) instr_rdata <= '0;
                else           data_rdata  <= '0;
            end
        end
    end

`ifdef MEMCTRL_TIMEOUT_EN
    // Counts cycles spent in WAIT; err_q marks the DONE cycle of an aborted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state_q == WAIT) ? tmo_cnt + TMO_W'(1) : '0;
            err_q   <= abort;
        end
    end
    assign err = (state_q == DONE) && err_q;
`else
    assign err = 1'b0;
`endif

    assign cmd_active = (state_q == REQ) || (state_q == WAIT);
    assign bus_addr   = cmd_active ? lat_addr  : '0;
    assign bus_wdata  = cmd_active ? lat_wdata : '0;
    assign bus_be     = cmd_active ? lat_be    : '0;
    assign bus_read   = cmd_active && !lat_write;
    assign bus_write  = cmd_active && lat_write;
    assign instr_ack  = (state_q == DONE) && lat_instr;
    assign data_ack   = (state_q == DONE) && !lat_instr;
    assign state      = state_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: table vectors, reset/abort sequences and random
// transactions against a transaction-level arbitration model.
module tb_mem_arbiter_ctrl;

    localparam int SL  = 2;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_ack;
    logic [31:0] instr_rdata;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        err;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_read;
    logic        bus_write;
    logic        bus_busy;
    logic [31:0] bus_rdata;
    logic [2:0]  state;

    mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_rdata(instr_rdata),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_be(data_be), .data_ack(data_ack), .data_rdata(data_rdata), .err(err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_read(bus_read),
        .bus_write(bus_write), .bus_busy(bus_busy), .bus_rdata(bus_rdata), .state(state)
    );

    always #5 clk = ~clk;

    // g: 0 none, 1 instr, 2 data read, 3 data write
    typedef struct {
        logic        ireq, drd, dwr;
        logic [31:0] iaddr, daddr, wdata;
        logic [3:0]  be;
        int          busy;
        logic [31:0] rdata;
        int          g;
    } vec_t;

    int          total  = 0;
    int          passed = 0;
    int          starve = 0;
    logic [31:0] exp_ird = '0;
    logic [31:0] exp_drd = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] st, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                           input logic chk_wd, input logic iack, input logic dack, input logic e);
        chk({tag, " state"}, {29'd0, state}, {29'd0, st});
        chk({tag, " bus_read"}, {31'd0, bus_read}, {31'd0, rd});
        chk({tag, " bus_write"}, {31'd0, bus_write}, {31'd0, wr});
        chk({tag, " bus_addr"}, bus_addr, addr);
        chk({tag, " bus_be"}, {28'd0, bus_be}, {28'd0, be});
        if (chk_wd) chk({tag, " bus_wdata"}, bus_wdata, wd);
        chk({tag, " instr_ack"}, {31'd0, instr_ack}, {31'd0, iack});
        chk({tag, " data_ack"}, {31'd0, data_ack}, {31'd0, dack});
        chk({tag, " err"}, {31'd0, err}, {31'd0, e});
        chk({tag, " instr_rdata"}, instr_rdata, exp_ird);
        chk({tag, " data_rdata"}, data_rdata, exp_drd);
    endtask

    task automatic scramble();
        instr_req  = 1'($urandom);
        data_read  = 1'($urandom);
        data_write = 1'($urandom);
        instr_addr = $urandom;
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_be    = 4'($urandom);
    endtask

    function automatic int model_grant(input vec_t v);
        if (v.ireq && starve == SL) return 1;
        if (v.drd) return 2;
        if (v.dwr) return 3;
        if (v.ireq) return 1;
        return 0;
    endfunction

    function automatic vec_t mk(input logic ireq, input logic drd, input logic dwr,
                                input logic [31:0] iaddr, input logic [31:0] daddr,
                                input logic [31:0] wdata, input logic [3:0] be, input int busy,
                                input logic [31:0] rdata, input int g);
        vec_t v;
        v.ireq = ireq; v.drd = drd; v.dwr = dwr; v.iaddr = iaddr; v.daddr = daddr;
        v.wdata = wdata; v.be = be; v.busy = busy; v.rdata = rdata; v.g = g;
        return v;
    endfunction

    // Starts and ends with the DUT in IDLE, one cycle before the sampling edge.
    task automatic run_txn(input vec_t v, input int g, input string tag);
        logic [31:0] a;
        logic [3:0]  be;
        logic        rd, wr;
        instr_req = v.ireq; data_read = v.drd; data_write = v.dwr;
        instr_addr = v.iaddr; data_addr = v.daddr; data_wdata = v.wdata; data_be = v.be;
        bus_busy = 1'b0; bus_rdata = $urandom;
        chk_out({tag, " idle"}, 3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        if (g == 0) begin
            chk_out({tag, " no-req"}, 3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            return;
        end
        if (g == 1) starve = 0;
        else if (!v.ireq) starve = 0;
        else if (starve < SL) starve++;
        a  = (g == 1) ? v.iaddr : v.daddr;
        rd = (g != 3);
        wr = (g == 3);
        be = wr ? v.be : 4'hF;
        scramble();
        bus_busy  = (v.busy > 0);
        bus_rdata = bus_busy ? $urandom : v.rdata;
        chk_out({tag, " req"}, 3'd1, rd, wr, a, be, v.wdata, wr, 0, 0, 0);
        for (int i = 0; i < v.busy; i++) begin
            tick();
            scramble();
            if (i == v.busy - 1) begin
                bus_busy = 1'b0;
                bus_rdata = v.rdata;
            end else begin
                bus_rdata = $urandom;
            end
            chk_out({tag, " wait"}, 3'd2, rd, wr, a, be, v.wdata, wr, 0, 0, 0);
        end
        tick();
        bus_busy = 1'b0;
        bus_rdata = $urandom;
        if (g == 1) exp_ird = v.rdata;
        else if (g == 2) exp_drd = v.rdata;
        chk_out({tag, " done"}, 3'd3, 0, 0, 0, 0, 0, 1, g == 1, g != 1, 0);
        instr_req = 0; data_read = 0; data_write = 0;
        tick();
        chk_out({tag, " post"}, 3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        vec_t v;
        tbl[0] = mk(0, 1, 0, 32'h0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 2);
        tbl[1] = mk(0, 0, 1, 32'h0, 32'h20, 32'h12345678, 4'b0011, 3, 32'h0BADF00D, 3);
        tbl[2] = mk(1, 1, 1, 32'h100, 32'h30, 32'h55, 4'hF, 0, 32'hA1A1A1A1, 2);
        tbl[3] = mk(1, 1, 1, 32'h104, 32'h34, 32'h66, 4'hF, 1, 32'hA2A2A2A2, 2);
        tbl[4] = mk(1, 1, 1, 32'h108, 32'h38, 32'h77, 4'hF, 0, 32'hA3A3A3A3, 1);
        tbl[5] = mk(1, 1, 1, 32'h10C, 32'h3C, 32'h88, 4'hF, 2, 32'hA4A4A4A4, 2);
        tbl[6] = mk(1, 0, 0, 32'h200, 32'h40, 32'h0, 4'h0, 0, 32'hC0DEC0DE, 1);
        tbl[7] = mk(1, 0, 1, 32'h204, 32'h44, 32'hFEEDFACE, 4'b1000, 1, 32'h11111111, 3);
        tbl[8] = mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0);

        rst = 1'b1;
        instr_req = 0; data_read = 0; data_write = 0;
        instr_addr = '0; data_addr = '0; data_wdata = '0; data_be = '0;
        bus_busy = 1'b0; bus_rdata = 32'hFFFFFFFF;
        tick();
        tick();
        chk_out("reset", 3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_out("idle after reset", 3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 9; i++) run_txn(tbl[i], tbl[i].g, $sformatf("vec%0d", i));

        // Reset during WAIT: transfer dropped with no ack, rdata and starvation cleared.
        data_read = 1'b1; data_addr = 32'h80; instr_req = 1'b1;
        tick();
        bus_busy = 1'b1;
        tick();
        chk_out("rst-mid wait", 3'd2, 1, 0, 32'h80, 4'hF, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        exp_ird = '0; exp_drd = '0; starve = 0;
        chk_out("rst-mid abort", 3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        rst = 1'b0; bus_busy = 1'b0;
        instr_req = 0; data_read = 0;
        tick();
        v = mk(1, 0, 0, 32'h300, 32'h0, 32'h0, 4'h0, 1, 32'h5A5A5A5A, 1);
        run_txn(v, 1, "after-rst instr");

`ifdef MEMCTRL_TIMEOUT_EN
        data_read = 1'b1; data_addr = 32'h90;
        tick();
        bus_busy = 1'b1;
        data_read = 1'b0;
        chk_out("tmo req", 3'd1, 1, 0, 32'h90, 4'hF, 0, 0, 0, 0, 0);
        for (int i = 0; i < TMO; i++) begin
            tick();
            chk_out($sformatf("tmo wait%0d", i), 3'd2, 1, 0, 32'h90, 4'hF, 0, 0, 0, 0, 0);
        end
        tick();
        exp_drd = '0;
        chk_out("tmo done", 3'd3, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        bus_busy = 1'b0;
        tick();
        starve = 0;
        chk_out("tmo post", 3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            v = mk(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   4'($urandom), int'($urandom_range(0, TMO - 1)), $urandom, 0);
            run_txn(v, model_grant(v), $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
